// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port round-robin arbiter in front of the single-port
// word data memory. Port 0 is the CPU load/store stage, port 1 the secondary
// master. Each grant lasts exactly one cycle. All outputs decode from the
// registered state, and the granted port's inputs pass through combinationally.
// Out-of-range word addresses raise err, suppress the write and read as zero.
// Optional feature: define DM_ARB_TRACE_EN to print one line per committed write.
module dm_port_arbiter #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned IDX_LSB     = 2,
  parameter int unsigned IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        dm_sel,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              last_reg;
  logic              last_next;
  logic [1:0][31:0]  addr_v;
  logic [1:0]        range_err;

  assign addr_v[0] = addr0;
  assign addr_v[1] = addr1;

  // Per-port range check: word index past the end, or any byte-address bit
  // above the index field set. The low byte-offset bits are ignored.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_range
      logic [IDX_W-1:0] idx;
      assign idx = addr_v[gi][IDX_LSB+IDX_W-1:IDX_LSB];
      assign range_err[gi] = ({{(32-IDX_W){1'b0}}, idx} >= DEPTH_WORDS) |
                             (|addr_v[gi][31:IDX_LSB+IDX_W]);
    end
  endgenerate

  // State and last-winner registers; port 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // Next-state: in a grant state the own request is being consumed, so only
  // the other port can follow directly; that gives strict alternation.
  always_comb begin
    state_next = IDLE;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1) state_next = last_reg ? GNT0 : GNT1;
        else if (req0)    state_next = GNT0;
        else if (req1)    state_next = GNT1;
        else              state_next = IDLE;
      end
      GNT0: begin
        last_next  = 1'b0;
        state_next = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        last_next  = 1'b1;
        state_next = req0 ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: route the granted port to the memory, everything zero when idle.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    dm_sel  = 1'b0;
    dm_addr = 32'd0;
    dm_data = 32'd0;
    dm_pc   = 32'd0;
    rdata   = 32'd0;
    case (state_reg)
      GNT0: begin
        gnt0    = 1'b1;
        busy    = 1'b1;
        err     = range_err[0];
        dm_sel  = we0 & ~range_err[0];
        dm_addr = addr0;
        dm_data = wdata0;
        dm_pc   = pc0;
        rdata   = range_err[0] ? 32'd0 : dm_out;
      end
      GNT1: begin
        gnt1    = 1'b1;
        busy    = 1'b1;
        err     = range_err[1];
        dm_sel  = we1 & ~range_err[1];
        dm_addr = addr1;
        dm_data = wdata1;
        dm_pc   = pc1;
        rdata   = range_err[1] ? 32'd0 : dm_out;
      end
      default: ;
    endcase
  end

`ifdef DM_ARB_TRACE_EN
  // Write trace: one line per write the memory actually commits.
  always_ff @(posedge clk) begin
    if (!reset && dm_sel) begin
      $display("@%h: *%h <= %h", dm_pc, dm_addr, dm_data);
    end
  end
`else
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter. The bench plays the data memory, keeps a
// transaction-level model (who owns the memory this cycle, plus a reference
// word array), compares every DUT output against it on each falling edge,
// and pins the model with hand-computed directed checks.
module tb_dm_port_arbiter;

  localparam int DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] pc    [2];
  logic        gnt0, gnt1, err, busy, dm_sel;
  logic [31:0] rdata, dm_addr, dm_data, dm_pc, dm_out;

  logic [31:0] dm_mem  [4096];
  logic [31:0] ref_mem [4096];

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_last  = 1;
  bit m_valid = 1'b0;

  bit rec = 1'b0;
  int gq[$];

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .pc0(pc[0]), .pc1(pc[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .err(err), .busy(busy),
    .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_data(dm_data), .dm_pc(dm_pc),
    .dm_out(dm_out)
  );

  // Bench-side data memory: combinational read, write on the rising edge.
  assign dm_out = dm_mem[dm_addr[13:2]];
  always @(posedge clk) begin
    if (dm_sel) dm_mem[dm_addr[13:2]] <= dm_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  // Model: the memory is owned by at most one port per cycle. A finished
  // owner hands over to the other port if it is waiting; from idle, a single
  // requester wins, and on a tie the port that did not go last wins.
  always @(posedge clk) begin
    if (m_owner >= 0) begin
      if (we[m_owner] && !addr_bad(addr[m_owner]))
        ref_mem[addr[m_owner] >> 2] = wdata[m_owner];
    end
    if (reset) begin
      m_owner = -1;
      m_last  = 1;
      m_valid = 1'b1;
    end else if (m_owner >= 0) begin
      m_last  = m_owner;
      m_owner = req[1 - m_owner] ? (1 - m_owner) : -1;
    end else if (req[0] && req[1]) begin
      m_owner = 1 - m_last;
    end else if (req[0]) begin
      m_owner = 0;
    end else if (req[1]) begin
      m_owner = 1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] a, rd_e;
      logic        bad, sel_e;
      a = 32'd0; rd_e = 32'd0; bad = 1'b0; sel_e = 1'b0;
      if (m_owner >= 0) begin
        a     = addr[m_owner];
        bad   = addr_bad(a);
        sel_e = we[m_owner] & ~bad;
        rd_e  = bad ? 32'd0 : ref_mem[a >> 2];
      end
      chk("gnt0",    {31'd0, gnt0},   {31'd0, m_owner == 0});
      chk("gnt1",    {31'd0, gnt1},   {31'd0, m_owner == 1});
      chk("busy",    {31'd0, busy},   {31'd0, m_owner >= 0});
      chk("err",     {31'd0, err},    {31'd0, bad});
      chk("dm_sel",  {31'd0, dm_sel}, {31'd0, sel_e});
      chk("dm_addr", dm_addr, (m_owner >= 0) ? a : 32'd0);
      chk("dm_data", dm_data, (m_owner >= 0) ? wdata[m_owner] : 32'd0);
      chk("dm_pc",   dm_pc,   (m_owner >= 0) ? pc[m_owner] : 32'd0);
      chk("rdata",   rdata,   rd_e);
      if (rec) gq.push_back(gnt0 ? 0 : (gnt1 ? 1 : 2));
    end
  end

  // One access on port p, held until granted. Returns the cycle count to the
  // grant and the DUT outputs seen in the grant cycle.
  task automatic access(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] pcv,
                        output int lat, output logic [31:0] rd, output logic e,
                        output logic s, output logic [31:0] da);
    bit got;
    got = 1'b0; lat = 0; rd = 'x; e = 'x; s = 'x; da = 'x;
    @(negedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; pc[p] = pcv;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((p == 0) ? gnt0 : gnt1) begin
        got = 1'b1; rd = rdata; e = err; s = dm_sel; da = dm_addr;
      end
    end
    chk($sformatf("grant_p%0d_timeout", p), {31'd0, got}, 32'd1);
    #1 req[p] = 1'b0;
    $display("port%0d %s addr=%h wdata=%h -> lat=%0d rdata=%h err=%b", p,
             w ? "WR" : "RD", a, d, lat, rd, e);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  int lat0, lat1;
  logic [31:0] rd0, rd1, da0, da1;
  logic e0, e1, s0, s1;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dm_mem[i]  = 32'd0;
      ref_mem[i] = 32'd0;
    end
    // Poison the words behind an out-of-range index so a leaked read shows up.
    dm_mem[3072] = 32'hDEADBEEF;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'd0; wdata[p] = 32'd0; pc[p] = 32'd0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt",  {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_sel",  {31'd0, dm_sel}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    #1 reset = 1'b0;

    // Single write then read back, plus misaligned and high-bit addresses.
    access(0, 1'b1, 32'h10, 32'hA5A5A5A5, 32'h100, lat0, rd0, e0, s0, da0);
    chk("wr_lat", lat0, 32'd1);
    chk("wr_sel", {31'd0, s0}, 32'd1);
    chk("wr_addr", da0, 32'h10);
    access(0, 1'b0, 32'h10, 32'h0, 32'h104, lat0, rd0, e0, s0, da0);
    chk("rd_data", rd0, 32'hA5A5A5A5);
    chk("rd_err", {31'd0, e0}, 32'd0);
    access(1, 1'b0, 32'h13, 32'h0, 32'h200, lat1, rd1, e1, s1, da1);
    chk("misalign_data", rd1, 32'hA5A5A5A5);
    chk("misalign_err", {31'd0, e1}, 32'd0);
    access(0, 1'b0, 32'h0001_0010, 32'h0, 32'h108, lat0, rd0, e0, s0, da0);
    chk("hibit_err", {31'd0, e0}, 32'd1);
    chk("hibit_rdata", rd0, 32'd0);

    // Simultaneous requests right after reset: port 0 first, then port 1.
    do_reset();
    fork
      access(0, 1'b1, 32'h20, 32'h11111111, 32'h300, lat0, rd0, e0, s0, da0);
      access(1, 1'b1, 32'h24, 32'h22222222, 32'h400, lat1, rd1, e1, s1, da1);
    join
    chk("tie_lat0", lat0, 32'd1);
    chk("tie_lat1", lat1, 32'd2);

    // Both held continuously: eight back-to-back alternating grants.
    do_reset();
    @(negedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; pc[0] = 32'h500;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; wdata[1] = 32'h0;        pc[1] = 32'h600;
    gq.delete();
    rec = 1'b1;
    for (int i = 0; i < 20 && gq.size() < 8; i++) begin
      @(negedge clk); #1;
    end
    rec = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
    chk("stream_len", gq.size(), 32'd8);
    for (int k = 0; k < 8 && k < gq.size(); k++) begin
      chk($sformatf("stream_%0d", k), gq[k], k % 2);
      $display("stream grant %0d -> port%0d", k, gq[k]);
    end

    // Range boundary: last valid word, then the first invalid one.
    access(1, 1'b1, 32'h2FFC, 32'hCAFEF00D, 32'h700, lat1, rd1, e1, s1, da1);
    chk("lastword_err", {31'd0, e1}, 32'd0);
    access(0, 1'b0, 32'h2FFC, 32'h0, 32'h704, lat0, rd0, e0, s0, da0);
    chk("lastword_rd", rd0, 32'hCAFEF00D);
    access(1, 1'b1, 32'h3000, 32'h55555555, 32'h708, lat1, rd1, e1, s1, da1);
    chk("oor_wr_err", {31'd0, e1}, 32'd1);
    chk("oor_wr_sel", {31'd0, s1}, 32'd0);
    access(1, 1'b0, 32'h3000, 32'h0, 32'h70C, lat1, rd1, e1, s1, da1);
    chk("oor_rd_err", {31'd0, e1}, 32'd1);
    chk("oor_rd_data", rd1, 32'd0);

    // Reset during a port 1 write grant, with port 0 waiting.
    @(negedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h50; wdata[1] = 32'h77; pc[1] = 32'h800;
    lat1 = 0;
    for (int i = 0; i < 20 && !gnt1; i++) begin
      @(negedge clk);
      lat1++;
    end
    chk("rstg_gnt1", {31'd0, gnt1}, 32'd1);
    #1;
    req[1] = 1'b0; reset = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h50; pc[0] = 32'h900;
    @(negedge clk);
    chk("rstg_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rstg_idle_busy", {31'd0, busy}, 32'd0);
    #1 reset = 1'b0;
    lat0 = 0;
    for (int i = 0; i < 20 && !gnt0; i++) begin
      @(negedge clk);
      lat0++;
    end
    chk("rstg_pending_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rstg_write_kept", rdata, 32'h77);
    $display("reset-in-grant: pending port0 granted after %0d cycles, rdata=%h", lat0, rdata);
    #1 req[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
